// File: rtl/hwpe_stream_package.sv
// Shared helpers for the HWPE stream/TCDM blocks.
package hwpe_stream_package;

  // Round-robin successor: (idx + 1) mod n without a divider, valid for any n >= 1.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// TCDM request/response channel: 32-bit address and data, byte enables.
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );
endinterface

// File: rtl/hwpe_stream_tcdm_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered TCDM transactions.
module hwpe_stream_tcdm_id_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rptr_q, wptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push, do_pop;

  // Pointer wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write; contents need no reset since occupancy is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  // Pointer and occupancy update; simultaneous push and pop keep count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM port among NB_IN_CHAN requesters,
// with an in-order ID FIFO routing variable-latency responses back.
module hwpe_stream_tcdm_rr_arbiter
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_IN_CHAN      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned HOLD_WINNER     = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  hwpe_stream_intf_tcdm.slave         in [NB_IN_CHAN-1:0],
  hwpe_stream_intf_tcdm.master        out,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int unsigned ID_W  = $clog2(NB_IN_CHAN);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NB_IN_CHAN-1:0] req_v, wen_v, gnt_v, rvalid_v;
  logic [31:0]           add_v   [NB_IN_CHAN];
  logic [31:0]           data_v  [NB_IN_CHAN];
  logic [3:0]            be_v    [NB_IN_CHAN];
  logic [31:0]           rdata_v [NB_IN_CHAN];

  logic [ID_W-1:0]  rr_q, lock_id_q, winner, fifo_head;
  logic             lock_q, err_q;
  logic             out_req, hs, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  for (genvar i = 0; i < NB_IN_CHAN; i++) begin : gen_chan
    assign req_v[i]      = in[i].req;
    assign wen_v[i]      = in[i].wen;
    assign add_v[i]      = in[i].add;
    assign data_v[i]     = in[i].data;
    assign be_v[i]       = in[i].be;
    assign in[i].gnt     = gnt_v[i];
    assign in[i].r_valid = rvalid_v[i];
    assign in[i].r_data  = rdata_v[i];
  end

  // Winner: locked requester if any, else first requester scanning from rr_q with wrap.
  always_comb begin
    int unsigned pos;
    logic        found;
    pos    = 0;
    found  = 1'b0;
    winner = rr_q;
    for (int unsigned k = 0; k < NB_IN_CHAN; k++) begin
      pos = 32'(rr_q) + k;
      if (pos >= NB_IN_CHAN) pos = pos - NB_IN_CHAN;
      if (!found && req_v[ID_W'(pos)]) begin
        winner = ID_W'(pos);
        found  = 1'b1;
      end
    end
    if (lock_q) winner = lock_id_q;
  end

  assign out_req  = (|req_v) && !fifo_full;
  assign hs       = out_req && out.gnt;
  assign pop      = out.r_valid && !fifo_empty;

  assign out.req  = out_req;
  assign out.add  = add_v[winner];
  assign out.wen  = wen_v[winner];
  assign out.be   = be_v[winner];
  assign out.data = data_v[winner];

  assign busy_o   = (fifo_count != '0);
  assign err_o    = err_q;

  // Grant demux to the winner and response demux to the FIFO head.
  always_comb begin
    gnt_v    = '0;
    rvalid_v = '0;
    for (int unsigned i = 0; i < NB_IN_CHAN; i++) begin
      gnt_v[i]    = hs && (winner == ID_W'(i));
      rvalid_v[i] = pop && (fifo_head == ID_W'(i));
      rdata_v[i]  = rvalid_v[i] ? out.r_data : '0;
    end
  end

  // Round-robin pointer advance on handshake; lock a stalled winner until granted.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (hs) begin
      rr_q   <= ID_W'(rr_next(32'(winner), NB_IN_CHAN));
      lock_q <= 1'b0;
    end else if ((HOLD_WINNER != 0) && out_req && !lock_q) begin
      lock_q    <= 1'b1;
      lock_id_q <= winner;
    end
  end

  // Sticky error on a response with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      err_q <= 1'b0;
    end else if (out.r_valid && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  hwpe_stream_tcdm_id_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push    (hs),
    .pop     (pop),
    .wdata   (winner),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_hwpe_stream_tcdm_rr_arbiter.sv
// Directed bench for the round-robin TCDM arbiter (4-ch/4-deep hold, 3-ch/2-deep no-hold).
module tb_hwpe_stream_tcdm_rr_arbiter;

  logic clk = 1'b0;
  logic rst, clr;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  // DUT A: 4 channels, 4 outstanding, hold winner
  logic [3:0]  a_req, a_wen, a_be, a_gnt, a_rv;
  logic [31:0] a_add [4];
  logic [31:0] a_data [4];
  logic [31:0] a_rdata [4];
  logic        a_busy, a_err;
  hwpe_stream_intf_tcdm a_in [3:0] ();
  hwpe_stream_intf_tcdm a_out ();

  for (genvar g = 0; g < 4; g++) begin : g_a
    assign a_in[g].req  = a_req[g];
    assign a_in[g].add  = a_add[g];
    assign a_in[g].wen  = a_wen[g];
    assign a_in[g].be   = a_be;
    assign a_in[g].data = a_data[g];
    assign a_gnt[g]     = a_in[g].gnt;
    assign a_rv[g]      = a_in[g].r_valid;
    assign a_rdata[g]   = a_in[g].r_data;
  end

  hwpe_stream_tcdm_rr_arbiter #(
    .NB_IN_CHAN      (4),
    .MAX_OUTSTANDING (4),
    .HOLD_WINNER     (1)
  ) u_dut_a (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clr),
    .in      (a_in),
    .out     (a_out),
    .busy_o  (a_busy),
    .err_o   (a_err)
  );

  // DUT B: 3 channels, 2 outstanding, no hold
  logic [2:0]  b_req, b_gnt, b_rv;
  logic [31:0] b_add [3];
  logic [31:0] b_rdata [3];
  logic        b_busy, b_err;
  hwpe_stream_intf_tcdm b_in [2:0] ();
  hwpe_stream_intf_tcdm b_out ();

  for (genvar g = 0; g < 3; g++) begin : g_b
    assign b_in[g].req  = b_req[g];
    assign b_in[g].add  = b_add[g];
    assign b_in[g].wen  = 1'b1;
    assign b_in[g].be   = 4'hF;
    assign b_in[g].data = 32'h0;
    assign b_gnt[g]     = b_in[g].gnt;
    assign b_rv[g]      = b_in[g].r_valid;
    assign b_rdata[g]   = b_in[g].r_data;
  end

  hwpe_stream_tcdm_rr_arbiter #(
    .NB_IN_CHAN      (3),
    .MAX_OUTSTANDING (2),
    .HOLD_WINNER     (0)
  ) u_dut_b (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clr),
    .in      (b_in),
    .out     (b_out),
    .busy_o  (b_busy),
    .err_o   (b_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs settle 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    a_req = '0; a_wen = '1; a_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_add[i]  = 32'h100 + 32'(i);
      a_data[i] = 32'hD0 + 32'(i);
    end
    b_req = '0;
    for (int i = 0; i < 3; i++) b_add[i] = 32'h200 + 32'(i);
    a_out.gnt = 1'b0; a_out.r_valid = 1'b0; a_out.r_data = '0;
    b_out.gnt = 1'b0; b_out.r_valid = 1'b0; b_out.r_data = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_err",  32'(a_err), 0);
    chk("rst_req",  32'(a_out.req), 0);
    chk("rst_gnt",  32'(a_gnt), 0);
    chk("rst_rv",   32'(a_rv), 0);

    // All channels requesting, response one cycle after each grant: 0,1,2,3,0
    a_out.gnt = 1'b1;
    a_req = 4'hF;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) a_req = '0;
      a_out.r_valid = (k > 0);
      a_out.r_data  = 32'hA0 + 32'(k);
      #1;
      if (k < 5) begin
        chk("t1_gnt", 32'(a_gnt), 32'(1) << (k % 4));
        chk("t1_add", a_out.add, 32'h100 + 32'(k % 4));
      end else begin
        chk("t1_req_idle", 32'(a_out.req), 0);
      end
      if (k > 0) begin
        chk("t1_rv", 32'(a_rv), 32'(1) << ((k - 1) % 4));
        chk("t1_rdata", a_rdata[2'((k - 1) % 4)], 32'hA0 + 32'(k));
      end
      cyc();
    end
    a_out.r_valid = 1'b0;
    #1;
    chk("t1_busy", 32'(a_busy), 0);
    chk("t1_err", 32'(a_err), 0);

    // rr_q=1 -> grant ch1 to get rr_q=2, then ch0+ch3 request: ch3 first
    a_req = 4'b0010;
    #1; chk("t2_g1", 32'(a_gnt), 32'h2);
    cyc();
    a_req = 4'b1001; a_out.r_valid = 1'b1; a_out.r_data = 32'hB1;
    #1;
    chk("t2_g3", 32'(a_gnt), 32'h8);
    chk("t2_add3", a_out.add, 32'h103);
    chk("t2_rv1", 32'(a_rv), 32'h2);
    chk("t2_rd1", a_rdata[1], 32'hB1);
    cyc();
    a_req = 4'b0001; a_out.r_data = 32'hB3;
    #1;
    chk("t2_g0", 32'(a_gnt), 32'h1);
    chk("t2_rv3", 32'(a_rv), 32'h8);
    cyc();
    a_req = '0; a_out.r_data = 32'hB0;
    #1; chk("t2_rv0", 32'(a_rv), 32'h1);
    cyc();
    a_out.r_valid = 1'b0;

    // rr_q=1 -> grant ch3 so rr_q=0, making ch0 outrank ch1 absent the lock
    a_req = 4'b1000;
    #1; chk("t3_g3", 32'(a_gnt), 32'h8);
    cyc();
    a_req = '0; a_out.r_valid = 1'b1; a_out.r_data = 32'h0;
    #1; chk("t3_rv3", 32'(a_rv), 32'h8);
    cyc();
    a_out.r_valid = 1'b0;
    a_add[1] = 32'h111; a_data[1] = 32'h222;
    a_req = 4'b0010; a_out.gnt = 1'b0;
    #1;
    chk("t3_req", 32'(a_out.req), 1);
    chk("t3_nogrant", 32'(a_gnt), 0);
    chk("t3_add_a", a_out.add, 32'h111);
    cyc();
    a_req = 4'b0011;
    #1;
    chk("t3_lock_add", a_out.add, 32'h111);
    chk("t3_lock_gnt", 32'(a_gnt), 0);
    cyc();
    #1;
    chk("t3_lock_add2", a_out.add, 32'h111);
    chk("t3_lock_data", a_out.data, 32'h222);
    cyc();
    a_out.gnt = 1'b1;
    #1;
    chk("t3_g1", 32'(a_gnt), 32'h2);
    chk("t3_data1", a_out.data, 32'h222);
    chk("t3_be", 32'(a_out.be), 32'hF);
    cyc();
    a_req = 4'b0001;
    #1; chk("t3_g0", 32'(a_gnt), 32'h1);
    cyc();
    a_req = '0; a_out.r_valid = 1'b1; a_out.r_data = 32'hE1;
    #1;
    chk("t3_rv1", 32'(a_rv), 32'h2);
    chk("t3_rd1", a_rdata[1], 32'hE1);
    cyc();
    a_out.r_data = 32'hE0;
    #1; chk("t3_rv0", 32'(a_rv), 32'h1);
    cyc();
    a_out.r_valid = 1'b0;
    #1; chk("t3_busy", 32'(a_busy), 0);

    // Variable latency: ch2 read, ch0 write, ch1 read; responses in order
    a_req = 4'b0100;
    #1;
    chk("t4_g2", 32'(a_gnt), 32'h4);
    chk("t4_wen2", 32'(a_out.wen), 1);
    cyc();
    a_req = 4'b0001; a_wen[0] = 1'b0;
    #1;
    chk("t4_g0", 32'(a_gnt), 32'h1);
    chk("t4_wen0", 32'(a_out.wen), 0);
    cyc();
    a_req = 4'b0010; a_wen[0] = 1'b1;
    #1; chk("t4_g1", 32'(a_gnt), 32'h2);
    cyc();
    a_req = '0; a_out.r_valid = 1'b1; a_out.r_data = 32'hC2;
    #1;
    chk("t4_rv2", 32'(a_rv), 32'h4);
    chk("t4_rd2", a_rdata[2], 32'hC2);
    chk("t4_rd0_zero", a_rdata[0], 32'h0);
    cyc();
    a_out.r_data = 32'hC0;
    #1;
    chk("t4_rv0", 32'(a_rv), 32'h1);
    chk("t4_rd0", a_rdata[0], 32'hC0);
    cyc();
    a_out.r_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_gap_rv", 32'(a_rv), 0);
      chk("t4_gap_busy", 32'(a_busy), 1);
      cyc();
    end
    a_out.r_valid = 1'b1; a_out.r_data = 32'hC1;
    #1;
    chk("t4_rv1", 32'(a_rv), 32'h2);
    chk("t4_rd1", a_rdata[1], 32'hC1);
    cyc();
    a_out.r_valid = 1'b0;
    #1; chk("t4_busy", 32'(a_busy), 0);

    // Unsolicited response sets sticky err; reset clears it and rr_q
    a_out.r_valid = 1'b1; a_out.r_data = 32'hFF;
    #1; chk("t5_drop_rv", 32'(a_rv), 0);
    cyc();
    a_out.r_valid = 1'b0;
    #1; chk("t5_err", 32'(a_err), 1);
    cyc();
    #1; chk("t5_err_sticky", 32'(a_err), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("t5_err_rst", 32'(a_err), 0);
    chk("t5_busy_rst", 32'(a_busy), 0);
    a_req = 4'hF;
    #1; chk("t5_g0_after_rst", 32'(a_gnt), 32'h1);
    cyc();
    a_req = '0; a_out.r_valid = 1'b1; a_out.r_data = 32'h77;
    #1; chk("t5_rv0", 32'(a_rv), 32'h1);
    cyc();
    #1; chk("t5_rv_none", 32'(a_rv), 0);
    cyc();
    a_out.r_valid = 1'b0;
    #1; chk("t5_err2", 32'(a_err), 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    #1; chk("t5_err_clr", 32'(a_err), 0);

    // DUT B: depth-2 full stall, no pop/push bypass, wrap over 3 channels
    b_req = 3'b111; b_out.gnt = 1'b1;
    #1;
    chk("b_req0", 32'(b_out.req), 1);
    chk("b_g0", 32'(b_gnt), 32'h1);
    chk("b_add0", b_out.add, 32'h200);
    cyc();
    #1;
    chk("b_g1", 32'(b_gnt), 32'h2);
    chk("b_busy", 32'(b_busy), 1);
    cyc();
    #1;
    chk("b_full_req", 32'(b_out.req), 0);
    chk("b_full_gnt", 32'(b_gnt), 0);
    chk("b_full_busy", 32'(b_busy), 1);
    cyc();
    b_out.r_valid = 1'b1; b_out.r_data = 32'hF0;
    #1;
    chk("b_nobypass_req", 32'(b_out.req), 0);
    chk("b_rv0", 32'(b_rv), 32'h1);
    chk("b_rd0", b_rdata[0], 32'hF0);
    cyc();
    b_out.r_valid = 1'b0;
    #1;
    chk("b_req_again", 32'(b_out.req), 1);
    chk("b_g2", 32'(b_gnt), 32'h4);
    cyc();
    b_out.r_valid = 1'b1; b_out.r_data = 32'hF1;
    #1;
    chk("b_full2_req", 32'(b_out.req), 0);
    chk("b_rv1", 32'(b_rv), 32'h2);
    cyc();
    b_out.r_valid = 1'b0;
    #1;
    chk("b_g0_wrap", 32'(b_gnt), 32'h1);
    chk("b_err", 32'(b_err), 0);
    cyc();
    b_req = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
